alu_shift_seq: RTL

// - Multi-cycle sequencer for the ALU shift path (SLL/SRL/SRA). It shifts at most STEP bits
//   per cycle and runs a remaining-count down to zero, so no full 32-way combinational

---
 rtl/alu_shift_seq.sv | 90 +++++++++
 1 files changed

// File: rtl/alu_shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer: shifts at most STEP bits per cycle until the
// remaining count reaches zero, then holds the result behind a valid/ready handshake.
module alu_shift_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_op,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpPass = 2'b11;
  localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [SHAMT_W-1:0] step_k;
  logic               accept;

  assign o_ready  = (state_q == StIdle) && !i_reset;
  assign o_valid  = (state_q == StDone);
  assign o_busy   = (state_q != StIdle);
  assign o_result = result_q;
  assign accept   = i_valid && o_ready;

  // Per-cycle shift never exceeds what is left, so the counter cannot underflow.
  assign step_k = (rem_q < StepAmt) ? rem_q : StepAmt;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    op_d     = op_q;
    rem_d    = rem_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          result_d = i_data;
          op_d     = i_op;
          rem_d    = i_shamt;
          state_d  = (i_shamt == '0 || i_op == OpPass) ? StDone : StShift;
        end
      end
      StShift: begin
        rem_d = rem_q - step_k;
        unique case (op_q)
          OpSll:   result_d = result_q << step_k;
          OpSrl:   result_d = result_q >> step_k;
          OpSra:   result_d = WIDTH'($signed(result_q) >>> step_k);
          default: result_d = result_q;
        endcase
        if (rem_d == '0) state_d = StDone;
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      op_q     <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
    end
  end

endmodule
